load_store_unit: RTL

//  Memory-stage LSU between the execute stage and the data memory (Dmem). Accepts one

---
 rtl/load_store_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory-stage load/store unit between execute and Dmem. Accepts
//             one request per handshake, builds byte enables and lane-aligned
//             store data, drives Dmem's edge-triggered store protocol, and
//             returns sign/zero-extended load data or a store acknowledgement
//             tagged with the destination register.
//  Build    : LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
//             accesses skip memory and return resp_error=1, resp_data=0.
//  Ports    : clock, reset           sync active-high reset
//             req_*                  request channel (valid/ready)
//             resp_*                 response channel (valid/ready)
//             mem_address/store_data/byte_enable/store_valid   to Dmem
//             mem_load_data/load_data_valid/store_complete     from Dmem
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
  parameter int TAG_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [TAG_WIDTH-1:0] resp_tag,
  output logic                 resp_error,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_store_data,
  output logic [3:0]           mem_byte_enable,
  output logic                 mem_store_valid,
  input  logic [31:0]          mem_load_data,
  input  logic                 mem_load_data_valid,
  input  logic                 mem_store_complete
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      addr;
  logic [1:0]       size;
  logic             load_unsigned;
  logic [31:0]      wdata;
  logic [CNT_W-1:0] counter;
  logic             misaligned;
  logic [3:0]       lane_be;
  logic [31:0]      lane_data;
  logic [31:0]      shifted;
  logic [31:0]      load_ext;

  // Alignment is judged on the incoming request so the trap can be taken
  // straight from IDLE without touching memory.
`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      default: misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // Store lane steering from the latched request. Misaligned low bits are
  // ignored: halves use addr[1] only, words always use lane 0.
  always_comb begin
    lane_be   = 4'b1111;
    lane_data = wdata;
    case (size)
      2'b00: begin
        lane_be   = 4'b0001 << addr[1:0];
        lane_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        lane_be   = addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
      end
      default: begin
        lane_be   = 4'b1111;
        lane_data = wdata;
      end
    endcase
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted  = mem_load_data;
    load_ext = mem_load_data;
    case (size)
      2'b00: begin
        shifted  = mem_load_data >> {addr[1:0], 3'b000};
        load_ext = {{24{~load_unsigned & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        shifted  = mem_load_data >> {addr[1], 4'b0000};
        load_ext = {{16{~load_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        shifted  = mem_load_data;
        load_ext = mem_load_data;
      end
    endcase
  end

  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_store_valid = 1'b0;
    mem_byte_enable = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)     state_next = RESP;
          else if (req_store) state_next = STORE;
          else                state_next = LOAD;
        end
      end
      LOAD: begin
        // The first LOAD cycle only presents the new address; load data is
        // trusted from the second cycle on, so a valid left over from the
        // previous access can never be captured.
        if ((counter != '0) && mem_load_data_valid) state_next = RESP;
      end
      STORE: begin
        mem_store_valid = 1'b1;
        mem_byte_enable = lane_be;
        if (mem_store_complete || (counter == CNT_LAST)) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      addr          <= '0;
      size          <= '0;
      load_unsigned <= 1'b0;
      wdata         <= '0;
      resp_data     <= '0;
      resp_tag      <= '0;
      resp_error    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          counter <= '0;
          if (req_valid) begin
            addr          <= req_addr;
            size          <= req_size;
            load_unsigned <= req_unsigned;
            wdata         <= req_wdata;
            resp_tag      <= req_tag;
            resp_data     <= '0;
            resp_error    <= misaligned;
          end
        end
        LOAD: begin
          if (counter == '0)          counter   <= CNT_W'(1);
          if (state_next == RESP)     resp_data <= load_ext;
        end
        STORE: begin
          counter <= counter + CNT_W'(1);
          if (!mem_store_complete && (counter == CNT_LAST)) resp_error <= 1'b1;
        end
        default: counter <= '0;
      endcase
    end
  end

  assign mem_address    = {addr[31:2], 2'b00};
  assign mem_store_data = lane_data;

endmodule
`default_nettype wire
